// File: rtl/axis_demux_1_2_pkg.sv
// Shared types and constants for the packet-aware 1:2 AXI-Stream demultiplexer.
package axis_demux_pkg;

    // Route state: IDLE means no packet in progress and the route follows sel;
    // M1/M2 mean a packet is locked to that master until its tlast beat.
    typedef enum logic [1:0] {
        ROUTE_IDLE = 2'd0,
        ROUTE_M1   = 2'd1,
        ROUTE_M2   = 2'd2
    } route_e;

    // Value of sel that steers a new packet to master 1.
    localparam logic SEL_M1 = 1'b1;

    // Translate the raw sel request into the master it selects.
    function automatic route_e sel_route(input logic sel);
        return (sel == SEL_M1) ? ROUTE_M1 : ROUTE_M2;
    endfunction

endpackage

// File: rtl/axis_demux_1_2_out_reg.sv
// One-entry registered AXI-Stream output stage. Accepts a beat whenever it is
// empty or being drained in the same cycle, so a continuous stream sees no bubbles.
module axis_out_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] tdata_i,
    input  logic          tlast_i,
    output logic [DW-1:0] tdata_o,
    output logic          tvalid_o,
    output logic          tlast_o,
    input  logic          tready_i,
    output logic          loadable_o
);

    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          load;

    // The entry can take a new beat when it is empty or its beat leaves this cycle.
    assign loadable_o = !tvalid_q || tready_i;
    assign load       = load_i && loadable_o;

    // Next-state selection: load wins, otherwise drain, otherwise hold (stalled beat stays put).
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (load) begin
            tdata_d  = tdata_i;
            tlast_d  = tlast_i;
            tvalid_d = 1'b1;
        end else if (tready_i) begin
            // Drained with nothing behind it: drop valid/last, keep the stale data.
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    // Output register with asynchronous reset; a beat held at reset is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data register is reset too, because the block presents all-zero outputs out of reset.
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/axis_demux_1_2.sv
// Packet-aware 1:2 AXI-Stream demultiplexer. The route is chosen from sel at the
// first beat of a packet and held until the tlast beat is accepted, so a packet
// never straddles the two outputs. Each output is a one-entry register stage.
module axis_demux_1_2
    import axis_demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m1_tdata,
    output logic          m1_tvalid,
    output logic          m1_tlast,
    input  logic          m1_tready,
    output logic [DW-1:0] m2_tdata,
    output logic          m2_tvalid,
    output logic          m2_tlast,
    input  logic          m2_tready,
    output logic          busy
);

    route_e state_q;
    logic   busy_q;
    route_e route;
    logic   m1_loadable;
    logic   m2_loadable;
    logic   route_loadable;
    logic   accept;
    logic   load_m1;
    logic   load_m2;

    // Effective route and slave handshake: only the routed output can stall the slave.
    always_comb begin
        route          = (state_q == ROUTE_IDLE) ? sel_route(sel) : state_q;
        route_loadable = (route == ROUTE_M1) ? m1_loadable : m2_loadable;
        s_tready       = !rst && route_loadable;
        accept         = s_tvalid && s_tready;
        load_m1        = accept && (route == ROUTE_M1);
        load_m2        = accept && (route == ROUTE_M2);
    end

    // Packet-lock state machine with registered busy flag; only accepted beats move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ROUTE_IDLE;
            busy_q  <= 1'b0;
        end else if (accept) begin
            if (s_tlast) begin
                state_q <= ROUTE_IDLE;
                busy_q  <= 1'b0;
            end else begin
                state_q <= route;
                busy_q  <= 1'b1;
            end
        end
    end

    assign busy = busy_q;

    axis_out_reg #(.DW(DW)) u_out_m1 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_m1),
        .tdata_i    (s_tdata),
        .tlast_i    (s_tlast),
        .tdata_o    (m1_tdata),
        .tvalid_o   (m1_tvalid),
        .tlast_o    (m1_tlast),
        .tready_i   (m1_tready),
        .loadable_o (m1_loadable)
    );

    axis_out_reg #(.DW(DW)) u_out_m2 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_m2),
        .tdata_i    (s_tdata),
        .tlast_i    (s_tlast),
        .tdata_o    (m2_tdata),
        .tvalid_o   (m2_tvalid),
        .tlast_o    (m2_tlast),
        .tready_i   (m2_tready),
        .loadable_o (m2_loadable)
    );

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Self-checking bench for axis_demux_1_2: directed scenarios followed by random
// packets, with a packet-level routing model feeding per-output scoreboards.
module tb_axis_demux_1_2;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m1_tdata;
    logic          m1_tvalid;
    logic          m1_tlast;
    logic          m1_tready;
    logic [DW-1:0] m2_tdata;
    logic          m2_tvalid;
    logic          m2_tlast;
    logic          m2_tready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Expected beats per output, stored as {tlast, tdata}.
    logic [DW:0] q1[$];
    logic [DW:0] q2[$];

    axis_demux_1_2 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m1_tdata  (m1_tdata),
        .m1_tvalid (m1_tvalid),
        .m1_tlast  (m1_tlast),
        .m1_tready (m1_tready),
        .m2_tdata  (m2_tdata),
        .m2_tvalid (m2_tvalid),
        .m2_tlast  (m2_tlast),
        .m2_tready (m2_tready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: packet-level reference model plus scoreboard pops. Inputs change at
    // posedge+1, so the negedge sees the exact handshake values of the next edge.
    int          cur_route = 2;
    bit          in_pkt = 1'b0;
    bit          held1 = 1'b0;
    bit          held2 = 1'b0;
    logic [DW:0] h1;
    logic [DW:0] h2;
    bit          pend = 1'b0;
    int          pend_route = 0;
    logic [DW:0] pend_beat;

    initial begin
        forever begin
            @(negedge clk);
            pend = 1'b0;
            if (rst) begin
                check("rst_s_tready", 32'(s_tready), 0);
                check("rst_m1_tvalid", 32'(m1_tvalid), 0);
                check("rst_m2_tvalid", 32'(m2_tvalid), 0);
                check("rst_busy", 32'(busy), 0);
                q1.delete();
                q2.delete();
                in_pkt = 1'b0;
                held1  = 1'b0;
                held2  = 1'b0;
            end else begin
                if (held1) check("m1_stable", 32'({m1_tvalid, m1_tlast, m1_tdata}), 32'({1'b1, h1}));
                if (held2) check("m2_stable", 32'({m2_tvalid, m2_tlast, m2_tdata}), 32'({1'b1, h2}));
                check("busy", 32'(busy), 32'(in_pkt));
                begin
                    int  r;
                    bit  exp_rdy;
                    r = in_pkt ? cur_route : (sel ? 1 : 2);
                    exp_rdy = (r == 1) ? (!m1_tvalid || m1_tready) : (!m2_tvalid || m2_tready);
                    check("s_tready", 32'(s_tready), 32'(exp_rdy));
                end
                if (m1_tvalid && m1_tready) begin
                    check("m1_beat_expected", 32'(q1.size() != 0), 1);
                    if (q1.size() != 0) check("m1_beat", 32'({m1_tlast, m1_tdata}), 32'(q1.pop_front()));
                end
                if (m2_tvalid && m2_tready) begin
                    check("m2_beat_expected", 32'(q2.size() != 0), 1);
                    if (q2.size() != 0) check("m2_beat", 32'({m2_tlast, m2_tdata}), 32'(q2.pop_front()));
                end
                held1 = m1_tvalid && !m1_tready;
                h1    = {m1_tlast, m1_tdata};
                held2 = m2_tvalid && !m2_tready;
                h2    = {m2_tlast, m2_tdata};
                if (s_tvalid && s_tready) begin
                    if (!in_pkt) cur_route = sel ? 1 : 2;
                    if (cur_route == 1) q1.push_back({s_tlast, s_tdata});
                    else                q2.push_back({s_tlast, s_tdata});
                    in_pkt     = !s_tlast;
                    pend       = 1'b1;
                    pend_route = cur_route;
                    pend_beat  = {s_tlast, s_tdata};
                end
            end
            @(posedge clk);
            #1;
            // One-cycle latency: an accepted beat is on its output right after the edge.
            if (pend && !rst) begin
                if (pend_route == 1) check("m1_latency", 32'({m1_tvalid, m1_tlast, m1_tdata}), 32'({1'b1, pend_beat}));
                else                 check("m2_latency", 32'({m2_tvalid, m2_tlast, m2_tdata}), 32'({1'b1, pend_beat}));
            end
        end
    end

    // Present one beat from posedge+1 and hold it until accepted; reports cycles taken.
    task automatic send_beat(input logic s, input logic [DW-1:0] d, input logic l, output int cyc);
        bit ok;
        sel      = s;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        ok       = 1'b0;
        cyc      = 0;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        check("send_accepted", 32'(ok), 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           cyc;
        logic [DW-1:0] vals[4];
        rst       = 1'b1;
        sel       = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m1_tready = 1'b1;
        m2_tready = 1'b1;

        @(posedge clk);
        #1;
        check("rst_m1_tdata", 32'(m1_tdata), 0);
        check("rst_m2_tdata", 32'(m2_tdata), 0);
        check("rst_m1_tlast", 32'(m1_tlast), 0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);

        // Single-beat packets alternating between outputs at full rate.
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            send_beat((i % 2) == 0, vals[i], 1'b1, cyc);
            check("single_beat_no_stall", 32'(cyc), 1);
        end
        idle_cycles(2);

        // 4-beat packet locked to m1 even though sel flips after beat 1.
        send_beat(1'b1, 8'hA0, 1'b0, cyc);
        check("lock_busy_after_first", 32'(busy), 1);
        send_beat(1'b0, 8'hA1, 1'b0, cyc);
        send_beat(1'b0, 8'hA2, 1'b0, cyc);
        send_beat(1'b0, 8'hA3, 1'b1, cyc);
        check("lock_busy_after_last", 32'(busy), 0);
        send_beat(1'b0, 8'hB0, 1'b1, cyc);
        idle_cycles(2);

        // Backpressure on m1: one beat buffers, then the slave stalls for 5 cycles.
        m1_tready = 1'b0;
        send_beat(1'b1, 8'hC0, 1'b0, cyc);
        check("bp_s_tready_low", 32'(s_tready), 0);
        fork
            send_beat(1'b1, 8'hC1, 1'b0, cyc);
            begin
                idle_cycles(5);
                m1_tready = 1'b1;
            end
        join
        check("bp_stall_cycles", 32'(cyc >= 5), 1);
        send_beat(1'b1, 8'hC2, 1'b1, cyc);
        idle_cycles(2);

        // m2 holds a stalled beat while m1 streams 3 beats back to back.
        m2_tready = 1'b0;
        send_beat(1'b0, 8'hD0, 1'b1, cyc);
        send_beat(1'b1, 8'hE0, 1'b0, cyc);
        check("indep_e0", 32'(cyc), 1);
        send_beat(1'b1, 8'hE1, 1'b0, cyc);
        check("indep_e1", 32'(cyc), 1);
        send_beat(1'b1, 8'hE2, 1'b1, cyc);
        check("indep_e2", 32'(cyc), 1);
        check("indep_m2_held", 32'({m2_tvalid, m2_tdata}), 32'({1'b1, 8'hD0}));
        m2_tready = 1'b1;
        idle_cycles(2);

        // Reset in the middle of beat 2 of a packet.
        send_beat(1'b1, 8'hF0, 1'b0, cyc);
        sel      = 1'b1;
        s_tdata  = 8'hF1;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_m1_tvalid", 32'(m1_tvalid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_s_tready", 32'(s_tready), 0);
        s_tvalid = 1'b0;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        check("post_rst_busy", 32'(busy), 0);
        send_beat(1'b0, 8'h5A, 1'b1, cyc);
        idle_cycles(2);

        // Random packets, random sel and output backpressure.
        begin
            int pkts      = 0;
            int beat_idx  = 0;
            int pkt_len   = $urandom_range(1, 6);
            int loops     = 0;
            bit acc;
            while (pkts < 100 && loops < 20000) begin
                @(negedge clk);
                acc = s_tvalid && s_tready;
                @(posedge clk);
                #1;
                loops++;
                if (acc) begin
                    s_tvalid = 1'b0;
                    if (s_tlast) begin
                        pkts++;
                        beat_idx = 0;
                        pkt_len  = $urandom_range(1, 6);
                    end else begin
                        beat_idx++;
                    end
                end
                m1_tready = ($urandom_range(0, 3) != 0);
                m2_tready = ($urandom_range(0, 3) != 0);
                sel       = 1'($urandom_range(0, 1));
                if (!s_tvalid && pkts < 100 && $urandom_range(0, 3) != 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = 8'($urandom_range(0, 255));
                    s_tlast  = (beat_idx == pkt_len - 1);
                end
            end
            check("random_packets_done", 32'(pkts), 100);
        end

        // Drain everything and confirm nothing was lost.
        s_tvalid  = 1'b0;
        m1_tready = 1'b1;
        m2_tready = 1'b1;
        idle_cycles(5);
        check("drain_m1_empty", 32'(q1.size()), 0);
        check("drain_m2_empty", 32'(q2.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
